// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit and aluControl.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RWB     = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_ADDI_EX = 4'd10,
    ST_ADDI_WB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // DECODE dispatch; FETCH as the result marks an unsupported opcode.
  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return ST_MEMADR;
      OP_RTYPE:     return ST_EXEC;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      OP_ADDI:      return ST_ADDI_EX;
      default:      return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Moore main control FSM for the unpipelined multicycle MIPS core, with
// memory-ready stalls in FETCH, MEMRD and MEMWR.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_op,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regDst,
  output logic       o_regWrite,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [1:0] o_pcSource,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = ST_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      ST_FETCH:   state_d = i_memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        state_d   = decode_next(i_op);
        illegal_d = (state_d == ST_FETCH);
      end
      ST_MEMADR:  state_d = (i_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   state_d = i_memReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:   state_d = i_memReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:    state_d = ST_RWB;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    o_iorD            = 1'b0;
    o_memRead         = 1'b0;
    o_memToReg        = 1'b0;
    o_regDst          = 1'b0;
    o_aluSrcA         = 1'b0;
    o_aluSrcB         = SRCB_RT;
    o_aluOp           = ALUOP_ADD;
    o_pcSource        = PCSRC_ALU;
    case (state_q)
      ST_FETCH: begin
        o_memRead    = 1'b1;
        o_aluSrcB    = SRCB_FOUR;
        pc_write_raw = i_memReady;
        ir_write_raw = i_memReady;
      end
      ST_DECODE: o_aluSrcB = SRCB_IMM_SH;
      ST_MEMADR, ST_ADDI_EX: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        o_memRead = 1'b1;
        o_iorD    = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_raw = 1'b1;
        o_memToReg    = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_raw = 1'b1;
        o_iorD        = 1'b1;
      end
      ST_EXEC: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = ALUOP_FUNC;
      end
      ST_RWB: begin
        reg_write_raw = 1'b1;
        o_regDst      = 1'b1;
      end
      ST_BRANCH: begin
        o_aluSrcA         = 1'b1;
        o_aluOp           = ALUOP_SUB;
        pc_write_cond_raw = 1'b1;
        o_pcSource        = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write_raw = 1'b1;
        o_pcSource   = PCSRC_JUMP;
      end
      ST_ADDI_WB: reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  // Architectural writes are masked while reset is held so nothing commits mid-reset.
  assign o_pcWrite     = pc_write_raw & i_rstn;
  assign o_pcWriteCond = pc_write_cond_raw & i_rstn;
  assign o_irWrite     = ir_write_raw & i_rstn;
  assign o_regWrite    = reg_write_raw & i_rstn;
  assign o_memWrite    = mem_write_raw & i_rstn;
  assign o_illegal     = illegal_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Table-driven check of main_control_fsm state sequencing and per-state strobes.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] op;
  logic       rdy;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, illegal;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  main_control_fsm dut (
    .i_clk(clk), .i_rstn(rstn), .i_op(op), .i_memReady(rdy),
    .o_pcWrite(pcWrite), .o_pcWriteCond(pcWriteCond), .o_iorD(iorD),
    .o_memRead(memRead), .o_memWrite(memWrite), .o_irWrite(irWrite),
    .o_memToReg(memToReg), .o_regDst(regDst), .o_regWrite(regWrite),
    .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB), .o_aluOp(aluOp),
    .o_pcSource(pcSource), .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  // ctl = {pcW,pcWC,iorD,memRd,memWr,irW,memToReg,regDst,regW,srcA, srcB, aluOp, pcSrc}
  localparam logic [15:0] C_F1  = {10'b1001010000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] C_F0  = {10'b0001000000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] C_DEC = {10'b0000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [15:0] C_MA  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] C_MRD = {10'b0011000000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_MWB = {10'b0000001010, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_MWR = {10'b0010100000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_EX  = {10'b0000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] C_RWB = {10'b0000000110, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_BR  = {10'b0100000001, 2'b00, 2'b01, 2'b01};
  localparam logic [15:0] C_JMP = {10'b1000000000, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] C_AEX = {10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] C_AWB = {10'b0000000010, 2'b00, 2'b00, 2'b00};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [5:0] o, logic r, logic [3:0] s, logic [15:0] c, logic i);
    vec_t x;
    x.op = o; x.rdy = r; x.st = s; x.ctl = c; x.ill = i;
    return x;
  endfunction

  function automatic logic [15:0] ctl_now();
    return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
            regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // first FETCH stalls, then lw
    vecs.push_back(v(LW, 0, 0, C_F0, 0));
    vecs.push_back(v(LW, 1, 0, C_F1, 0));
    vecs.push_back(v(LW, 1, 1, C_DEC, 0));
    vecs.push_back(v(LW, 1, 2, C_MA, 0));
    vecs.push_back(v(LW, 1, 3, C_MRD, 0));
    vecs.push_back(v(LW, 1, 4, C_MWB, 0));
    vecs.push_back(v(RT, 1, 0, C_F1, 0));
    vecs.push_back(v(RT, 1, 1, C_DEC, 0));
    vecs.push_back(v(RT, 1, 6, C_EX, 0));
    vecs.push_back(v(RT, 1, 7, C_RWB, 0));
    vecs.push_back(v(BEQ, 1, 0, C_F1, 0));
    vecs.push_back(v(BEQ, 1, 1, C_DEC, 0));
    vecs.push_back(v(BEQ, 1, 8, C_BR, 0));
    vecs.push_back(v(JMP, 1, 0, C_F1, 0));
    vecs.push_back(v(JMP, 1, 1, C_DEC, 0));
    vecs.push_back(v(JMP, 1, 9, C_JMP, 0));
    vecs.push_back(v(ADDI, 1, 0, C_F1, 0));
    vecs.push_back(v(ADDI, 1, 1, C_DEC, 0));
    vecs.push_back(v(ADDI, 1, 10, C_AEX, 0));
    vecs.push_back(v(ADDI, 1, 11, C_AWB, 0));
    // sw with three stall cycles in MEMWR
    vecs.push_back(v(SW, 1, 0, C_F1, 0));
    vecs.push_back(v(SW, 1, 1, C_DEC, 0));
    vecs.push_back(v(SW, 1, 2, C_MA, 0));
    vecs.push_back(v(SW, 0, 5, C_MWR, 0));
    vecs.push_back(v(SW, 0, 5, C_MWR, 0));
    vecs.push_back(v(SW, 0, 5, C_MWR, 0));
    vecs.push_back(v(SW, 1, 5, C_MWR, 0));
    // illegal opcode; the following FETCH stalls, flag lasts one cycle only
    vecs.push_back(v(BAD, 1, 0, C_F1, 0));
    vecs.push_back(v(BAD, 1, 1, C_DEC, 0));
    vecs.push_back(v(BAD, 0, 0, C_F0, 1));
    vecs.push_back(v(BAD, 0, 0, C_F0, 0));
    vecs.push_back(v(BEQ, 1, 0, C_F1, 0));
    vecs.push_back(v(BEQ, 1, 1, C_DEC, 0));
    vecs.push_back(v(BEQ, 1, 8, C_BR, 0));

    // reset with memReady high: FETCH, write strobes masked
    rstn = 1'b0; rdy = 1'b1; op = LW;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({pcWrite, pcWriteCond, irWrite, regWrite, memWrite}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      op  = vecs[i].op;
      rdy = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      @(posedge clk);
      @(negedge clk);
    end

    // reset asserted asynchronously while lw is stalled in MEMRD
    op = LW; rdy = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rdy = 1'b0;
    #1 chk("midrst_pre_state", 32'(state), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_async_state", 32'(state), 32'd0);
    chk("midrst_strobes", 32'({pcWrite, pcWriteCond, irWrite, regWrite, memWrite}), 32'd0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_memwb", 32'(state), 32'd0);
    chk("midrst_irwrite_masked", 32'({irWrite, pcWrite, regWrite}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_decode", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the unpipelined MIPS core. It sequences each instruction through fetch, decode, execute, memory and write-back states from the instruction opcode. It produces the datapath strobes and mux selects, including the 2-bit ALU operation class consumed directly by `aluControl`. The block holds a memory-ready handshake so fetch and data accesses can stall.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `i_clk`, in, 1: core clock; all state updates on the rising edge.
- `i_rstn`, in, 1: reset, asynchronous and active-low.
- `i_op`, in, 6: opcode field `instr[31:26]` from the instruction register; valid from DECODE onward.
- `i_memReady`, in, 1: memory has completed the current read or write this cycle.
- `o_pcWrite`, out, 1: unconditional PC load.
- `o_pcWriteCond`, out, 1: PC load qualified by ALU zero in the datapath (beq).
- `o_iorD`, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- `o_memRead`, out, 1: memory read request.
- `o_memWrite`, out, 1: memory write request.
- `o_irWrite`, out, 1: instruction register load.
- `o_memToReg`, out, 1: write-back data select; 1 = MDR, 0 = ALUOut.
- `o_regDst`, out, 1: destination register; 1 = rd, 0 = rt.
- `o_regWrite`, out, 1: register file write.
- `o_aluSrcA`, out, 1: ALU A operand; 0 = PC, 1 = rs.
- `o_aluSrcB`, out, 2: ALU B operand; 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `o_aluOp`, out, 2: operation class to `aluControl`; 00 = add, 01 = sub, 10 = R-type function.
- `o_pcSource`, out, 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `o_illegal`, out, 1: registered one-cycle flag for an unsupported opcode.
- `o_state`, out, 4: current state, for debug and the bench.

## Operation
- Moore FSM with a 4-bit state register. Outputs are a combinational decode of the state; any strobe not listed for a state is 0.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- Per-state outputs and transitions:
  - FETCH (0): memRead=1, aluSrcB=01, aluOp=00, pcSource=00. pcWrite and irWrite equal `i_memReady`. Stays in FETCH while `i_memReady`=0; goes to DECODE when it is 1.
  - DECODE (1): aluSrcB=11, aluOp=00. Next state by `i_op`: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, j → JUMP, addi → ADDI_EX. Any other opcode → FETCH, with `o_illegal` set for the next cycle.
  - MEMADR (2): aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): memRead=1, iorD=1. Holds until `i_memReady`=1, then goes to MEMWB.
  - MEMWB (4): regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
  - MEMWR (5): memWrite=1, iorD=1. Holds until `i_memReady`=1, then goes to FETCH.
  - EXEC (6): aluSrcA=1, aluSrcB=00, aluOp=10. Goes to RWB.
  - RWB (7): regWrite=1, regDst=1. Goes to FETCH.
  - BRANCH (8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Goes to FETCH.
  - JUMP (9): pcWrite=1, pcSource=10. Goes to FETCH.
  - ADDI_EX (10): aluSrcA=1, aluSrcB=10, aluOp=00. Goes to ADDI_WB.
  - ADDI_WB (11): regWrite=1, regDst=0, memToReg=0. Goes to FETCH.
- Unused encodings 12–15 go to FETCH on the next edge; outputs in those states are all 0.
- `i_op` is sampled only in DECODE and MEMADR. IR stability is guaranteed because irWrite is asserted only in FETCH.

## Timing
- Reset:
  - State is FETCH immediately on `i_rstn` falling; `o_illegal`=0.
  - While `i_rstn`=0, pcWrite, pcWriteCond, irWrite, regWrite and memWrite are forced to 0.
  - memRead=1, aluSrcB=01 and `o_state`=0 may show during reset.
- First FETCH edge after reset release: taken only if `i_memReady`=1.
- Instruction latency with `i_memReady` held at 1:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - illegal 2 cycles
- Each stall cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs in a held state do not change, except that pcWrite and irWrite in FETCH follow `i_memReady` combinationally.
- `o_illegal` is high for exactly the FETCH cycle following the illegal DECODE. If that FETCH stalls, `o_illegal` is still only one cycle.
- Reset asserted mid-instruction (any state): returns to FETCH asynchronously. No partial register or memory write is issued after the reset edge.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - `o_aluOp` constants (00 / 01 / 10), which `aluControl` also uses;
  - `o_aluSrcB` and `o_pcSource` select encodings.
- Single module; no sub-module. Output decode is one case statement on state.

## Test plan
- Reset: hold `i_rstn`=0 with `i_memReady`=1 → `o_state`=0, all write strobes 0. After release, the first edge reaches DECODE.
- lw, `i_memReady`=1: `i_op`=100011 → state sequence 0,1,2,3,4,0. aluOp=00 in states 0, 1 and 2; regWrite=1 and memToReg=1 only in state 4.
- R-type then beq: `i_op`=000000 → 0,1,6,7,0 with aluOp=10 in state 6 and regDst=1 in state 7. Then `i_op`=000100 → 0,1,8,0 with aluOp=01 and pcWriteCond=1 in state 8.
- Stall: sw with `i_memReady`=0 for 3 cycles in MEMWR → memWrite=1 for 4 consecutive cycles, then state 0. In FETCH with `i_memReady`=0, irWrite=0 and pcWrite=0.
- Illegal: `i_op`=111111 in DECODE → next state 0, `o_illegal`=1 for exactly 1 cycle, and no regWrite or memWrite at any point.
- Reset mid-op: assert `i_rstn`=0 asynchronously while in MEMRD → `o_state`=0 before the next clock edge, and MEMWB is never entered.
